// File: rtl/ov7670_config_seq.sv
// OV7670 configuration sequencer: walks the register ROM from address 0 and
// issues one SCCB write per {reg, val} entry, honouring delay and end markers.
module ov7670_config_seq #(
    parameter int unsigned DELAY_CYCLES   = 250_000,
    parameter bit          START_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  wr_count
);

    localparam int unsigned CntW = $clog2(DELAY_CYCLES + 1);
    localparam logic [15:0] EntryEnd   = 16'hFFFF;
    localparam logic [15:0] EntryDelay = 16'hFFF0;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StSend,
        StGuard,
        StWait,
        StDelay,
        StNext,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        rom_addr_q, rom_addr_d;
    logic [7:0]        sccb_reg_q, sccb_reg_d;
    logic [7:0]        sccb_val_q, sccb_val_d;
    logic [7:0]        wr_count_q, wr_count_d;
    logic [CntW-1:0]   delay_cnt_q, delay_cnt_d;
    logic              armed_q, armed_d;
    logic              go_idle;

    // Auto-start is a one-shot token loaded by reset and consumed on leaving IDLE.
    assign go_idle = start | armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q  <= 8'h00;
            sccb_reg_q  <= 8'h00;
            sccb_val_q  <= 8'h00;
            wr_count_q  <= 8'h00;
            delay_cnt_q <= '0;
            armed_q     <= START_ON_RESET;
        end else begin
            rom_addr_q  <= rom_addr_d;
            sccb_reg_q  <= sccb_reg_d;
            sccb_val_q  <= sccb_val_d;
            wr_count_q  <= wr_count_d;
            delay_cnt_q <= delay_cnt_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (go_idle) state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (rom_dout == EntryEnd) begin
                    state_d = StDone;
                end else if (rom_dout == EntryDelay) begin
                    state_d = StDelay;
                end else begin
                    state_d = StSend;
                end
            end
            StSend:   if (sccb_ready) state_d = StGuard;
            StGuard:  state_d = StWait;
            StWait:   if (sccb_ready) state_d = StNext;
            StDelay:  if (delay_cnt_q == '0) state_d = StNext;
            StNext:   state_d = (rom_addr_q == 8'hFF) ? StDone : StFetch;
            StDone:   if (start) state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        rom_addr_d  = rom_addr_q;
        sccb_reg_d  = sccb_reg_q;
        sccb_val_d  = sccb_val_q;
        wr_count_d  = wr_count_q;
        delay_cnt_d = delay_cnt_q;
        armed_d     = armed_q;
        unique case (state_q)
            StIdle: begin
                if (go_idle) begin
                    rom_addr_d = 8'h00;
                    wr_count_d = 8'h00;
                    armed_d    = 1'b0;
                end
            end
            StDecode: begin
                if (rom_dout == EntryDelay) begin
                    delay_cnt_d = CntW'(DELAY_CYCLES - 1);
                end else if (rom_dout != EntryEnd) begin
                    sccb_reg_d = rom_dout[15:8];
                    sccb_val_d = rom_dout[7:0];
                end
            end
            StSend: begin
                if (sccb_ready && (wr_count_q != 8'hFF)) begin
                    wr_count_d = wr_count_q + 8'd1;
                end
            end
            StDelay: begin
                if (delay_cnt_q != '0) begin
                    delay_cnt_d = delay_cnt_q - 1'b1;
                end
            end
            StNext: begin
                // Address 0xFF is the last entry; the table never wraps.
                if (rom_addr_q != 8'hFF) begin
                    rom_addr_d = rom_addr_q + 8'd1;
                end
            end
            StDone: begin
                if (start) begin
                    rom_addr_d = 8'h00;
                    wr_count_d = 8'h00;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        sccb_start = (state_q == StSend) && sccb_ready;
        busy       = (state_q != StIdle) && (state_q != StDone);
        done       = (state_q == StDone);
        rom_addr   = rom_addr_q;
        sccb_reg   = sccb_reg_q;
        sccb_val   = sccb_val_q;
        wr_count   = wr_count_q;
    end

endmodule
